// File: rtl/pearson_pkg.sv
// Shared types and defaults for the Pearson hash byte feeder.
package pearson_pkg;

  // Default FIFO depth in bytes (power of two, 2..64).
  localparam int DEPTH_DEF = 8;

  // Default width of the message-length counter.
  localparam int LEN_W_DEF = 8;

  // One message byte.
  typedef logic [7:0] byte_t;

  // One FIFO entry: the byte plus its end-of-message marker (9 bits).
  typedef struct packed {
    logic  last;
    byte_t data;
  } entry_t;

  // Framing state: START means the next popped byte opens a message.
  typedef enum logic {
    ST_START = 1'b0,
    ST_BODY  = 1'b1
  } state_e;

endpackage

// File: rtl/pearson_byte_fifo.sv
// In-order FIFO of {last, byte} entries. Pointers carry one extra wrap
// bit so that full and empty are distinguishable when the indices match.
// Read data is forced to zero while empty, so downstream never sees
// stale memory contents.
module pearson_byte_fifo
  import pearson_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic   clk_i,
  input  logic   reset_ni,
  input  logic   wr_en_i,
  input  entry_t wr_data_i,
  input  logic   rd_en_i,
  output entry_t rd_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  // Write pointer: advances on every accepted push, wraps modulo 2*DEPTH.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Read pointer: advances on every pop.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
    end else if (rd_en_i) begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage array; contents need no reset because reads are masked when empty.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Status flags and masked read data, all derived from registered pointers.
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_data_o = '0;
    if (!empty_o) begin
      rd_data_o = mem[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/pearson_byte_feeder.sv
// Byte feeder for a Pearson hash stage. Buffers upstream message bytes,
// tags the first and last byte of each message for the hash stage, and
// reports the length of each completed message (saturating, with an
// overflow flag).
//
// Handshake: both interfaces use strict valid/ready. A transfer happens
// on a rising edge where valid and ready are both 1. A source holds its
// payload stable while valid is high and ready is low, and never waits
// for ready before raising valid. Ready here never depends
// combinationally on the opposite side's ready.
module pearson_byte_feeder
  import pearson_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  byte_t            s_byte_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output byte_t            h_byte_o,
  output logic             h_valid_o,
  output logic             h_first_o,
  output logic             h_last_o,
  input  logic             h_ready_i,
  output logic [LEN_W-1:0] msg_len_o,
  output logic             len_valid_o,
  output logic             len_ovf_o,
  output state_e           state_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // Handshake and FIFO wiring
  logic   push;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t wr_entry;
  entry_t rd_entry;

  // Goes high on the first edge after reset is released, so s_ready_o is
  // low throughout the reset cycle and comes from registered state only.
  logic rst_done_q;

  // Framing FSM
  state_e state_q;
  state_e state_d;

  // Length tracking
  logic [LEN_W-1:0] len_cnt_q;
  logic [LEN_W-1:0] len_cnt_d;
  logic [LEN_W-1:0] len_inc;
  logic [LEN_W-1:0] msg_len_q;
  logic [LEN_W-1:0] msg_len_d;
  logic             len_valid_q;
  logic             len_valid_d;
  logic             len_ovf_q;
  logic             len_ovf_d;

  // Tracks whether the block is out of reset, gating upstream ready.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
    end
  end

  // Handshake qualification and downstream presentation.
  always_comb begin
    s_ready_o     = rst_done_q && !fifo_full;
    h_valid_o     = !fifo_empty;
    push          = s_valid_i && s_ready_o;
    pop           = h_valid_o && h_ready_i;
    wr_entry.last = s_last_i;
    wr_entry.data = s_byte_i;
    h_byte_o      = rd_entry.data;
    h_last_o      = h_valid_o && rd_entry.last;
    h_first_o     = h_valid_o && (state_q == ST_START);
  end

  pearson_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Framing FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing FSM next state: a popped last byte always returns to START,
  // so a one-byte message is tagged first and last together.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      case (state_q)
        ST_START: state_d = rd_entry.last ? ST_START : ST_BODY;
        ST_BODY:  state_d = rd_entry.last ? ST_START : ST_BODY;
        default:  state_d = ST_START;
      endcase
    end
  end

  // Length next-state: count pops, saturate, and publish on the last byte.
  // The true count exceeded the maximum exactly when the counter had
  // already saturated before the closing byte was popped.
  always_comb begin
    len_cnt_d   = len_cnt_q;
    msg_len_d   = msg_len_q;
    len_ovf_d   = len_ovf_q;
    len_valid_d = 1'b0;
    len_inc     = (len_cnt_q == LEN_MAX) ? LEN_MAX : (len_cnt_q + LEN_W'(1));
    if (pop) begin
      if (rd_entry.last) begin
        len_cnt_d   = '0;
        msg_len_d   = len_inc;
        len_ovf_d   = (len_cnt_q == LEN_MAX);
        len_valid_d = 1'b1;
      end else begin
        len_cnt_d   = len_inc;
      end
    end
  end

  // Length registers; msg_len_o and len_ovf_o hold until the next message.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      len_cnt_q   <= '0;
      msg_len_q   <= '0;
      len_valid_q <= 1'b0;
      len_ovf_q   <= 1'b0;
    end else begin
      len_cnt_q   <= len_cnt_d;
      msg_len_q   <= msg_len_d;
      len_valid_q <= len_valid_d;
      len_ovf_q   <= len_ovf_d;
    end
  end

  // Registered length outputs and FSM state for observation.
  always_comb begin
    msg_len_o   = msg_len_q;
    len_valid_o = len_valid_q;
    len_ovf_o   = len_ovf_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_pearson_byte_feeder.sv
// Directed testbench for pearson_byte_feeder. Inputs change on the falling
// edge; a monitor records every pop and every length report shortly after
// the falling edge, and each scenario compares them with hand-built
// expected queues.
module tb_pearson_byte_feeder;
  import pearson_pkg::*;

  localparam int DEPTH = 8;
  localparam int LEN_W = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  byte_t            s_byte = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  byte_t            h_byte;
  logic             h_valid;
  logic             h_first;
  logic             h_last;
  logic             h_ready = 1'b0;
  logic [LEN_W-1:0] msg_len;
  logic             len_valid;
  logic             len_ovf;
  state_e           state;

  pearson_byte_feeder #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .s_byte_i    (s_byte),
    .s_valid_i   (s_valid),
    .s_last_i    (s_last),
    .s_ready_o   (s_ready),
    .h_byte_o    (h_byte),
    .h_valid_o   (h_valid),
    .h_first_o   (h_first),
    .h_last_o    (h_last),
    .h_ready_i   (h_ready),
    .msg_len_o   (msg_len),
    .len_valid_o (len_valid),
    .len_ovf_o   (len_ovf),
    .state_o     (state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: pops are {first, last, byte}; length reports are {ovf, len}.
  logic [9:0]       obs_q[$];
  logic [9:0]       exp_q[$];
  logic [LEN_W:0]   len_obs_q[$];
  logic [LEN_W:0]   len_exp_q[$];

  // Monitor: samples mid-cycle, after inputs have settled for the next edge.
  always begin
    @(negedge clk);
    #2;
    if (reset_ni) begin
      if (h_valid && h_ready) obs_q.push_back({h_first, h_last, h_byte});
      if (len_valid) len_obs_q.push_back({len_ovf, msg_len});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers one byte and returns just after the edge that accepts it.
  task automatic push_byte(input byte_t b, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_byte  = b;
    s_last  = last;
    #1;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: s_ready stayed %b for byte %h, required 1", s_ready, b);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic clear_sb();
    obs_q.delete();
    exp_q.delete();
    len_obs_q.delete();
    len_exp_q.delete();
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL reset_h_valid: got %b required 0", h_valid); end
    checks++; if (h_first !== 1'b0) begin errors++; $display("FAIL reset_h_first: got %b required 0", h_first); end
    checks++; if (h_last !== 1'b0) begin errors++; $display("FAIL reset_h_last: got %b required 0", h_last); end
    checks++; if (h_byte !== 8'h00) begin errors++; $display("FAIL reset_h_byte: got %h required 00", h_byte); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
    checks++; if (msg_len !== 8'd0) begin errors++; $display("FAIL reset_msg_len: got %0d required 0", msg_len); end
    checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL reset_len_valid: got %b required 0", len_valid); end
    checks++; if (len_ovf !== 1'b0) begin errors++; $display("FAIL reset_len_ovf: got %b required 0", len_ovf); end
    checks++; if (state !== ST_START) begin errors++; $display("FAIL reset_state: got %0d required START", state); end
    reset_ni = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b required 1", s_ready); end
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL post_reset_h_valid: got %b required 0", h_valid); end
  endtask

  task automatic test_basic();
    clear_sb();
    h_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b1; s_byte = 8'h41; s_last = 1'b0;
    #1;
    checks++; if (h_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: h_valid got %b required 0", h_valid); end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    checks++; if (h_byte !== 8'h41) begin errors++; $display("FAIL basic_latency_byte: got %h required 41", h_byte); end
    checks++; if (h_first !== 1'b1) begin errors++; $display("FAIL basic_latency_first: got %b required 1", h_first); end
    push_byte(8'h42, 1'b0);
    push_byte(8'h43, 1'b1);
    idle(5);
    exp_q = '{10'h241, 10'h042, 10'h143};
    len_exp_q = '{9'd3};
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_pop_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_pop[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (len_obs_q.size() != 1) begin errors++; $display("FAIL basic_len_pulses: got %0d required 1", len_obs_q.size()); end
    else begin
      checks++; if (len_obs_q[0] !== len_exp_q[0]) begin errors++; $display("FAIL basic_len: got %h required %h", len_obs_q[0], len_exp_q[0]); end
    end
    checks++; if (msg_len !== 8'd3) begin errors++; $display("FAIL basic_len_hold: got %0d required 3", msg_len); end
  endtask

  task automatic test_single();
    clear_sb();
    h_ready = 1'b1;
    push_byte(8'h7E, 1'b1);
    idle(4);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_pop_count: got %0d required 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== 10'h37E) begin errors++; $display("FAIL single_pop: got %h required 37e", obs_q[0]); end
    end
    checks++; if (len_obs_q.size() != 1) begin errors++; $display("FAIL single_len_pulses: got %0d required 1", len_obs_q.size()); end
    else begin
      checks++; if (len_obs_q[0] !== 9'd1) begin errors++; $display("FAIL single_len: got %h required 001", len_obs_q[0]); end
    end
  endtask

  task automatic test_full_then_back_to_back();
    clear_sb();
    h_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i), (i == DEPTH - 1));
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b required 0", s_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++; if (h_byte !== 8'h80 || h_first !== 1'b1 || h_valid !== 1'b1) begin
        errors++; $display("FAIL full_hold[%0d]: byte %h first %b valid %b required 80 1 1", k, h_byte, h_first, h_valid);
      end
    end
    // Full FIFO: offer a new one-byte message and release the hash stage together.
    @(negedge clk);
    s_valid = 1'b1; s_byte = 8'h88; s_last = 1'b1; h_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_push_blocked: s_ready got %b required 0", s_ready); end
    @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b required 1", s_ready); end
    checks++; if (h_byte !== 8'h81) begin errors++; $display("FAIL after_pop_byte: got %h required 81", h_byte); end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    idle(14);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == 0), (i == DEPTH - 1), 8'h80 + 8'(i)});
    exp_q.push_back(10'h388);
    len_exp_q = '{9'd8, 9'd1};
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_pop_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_pop[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (len_obs_q.size() != 2) begin errors++; $display("FAIL full_len_pulses: got %0d required 2", len_obs_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (len_obs_q[i] !== len_exp_q[i]) begin errors++; $display("FAIL full_len[%0d]: got %h required %h", i, len_obs_q[i], len_exp_q[i]); end
    end
  endtask

  // Messages of 255 bytes (largest exact count) and 300 bytes (overflow).
  task automatic test_long();
    int lens[2];
    lens = '{255, 300};
    clear_sb();
    h_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < lens[m]; i++) begin
        push_byte(8'(i), (i == lens[m] - 1));
        exp_q.push_back({(i == 0), (i == lens[m] - 1), 8'(i)});
      end
      idle(3);
    end
    len_exp_q = '{9'h0FF, 9'h1FF};
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL long_pop_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        checks++; errors++; $display("FAIL long_pop[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
        break;
      end
    end
    checks++; if (len_obs_q.size() != 2) begin errors++; $display("FAIL long_len_pulses: got %0d required 2", len_obs_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (len_obs_q[i] !== len_exp_q[i]) begin errors++; $display("FAIL long_len[%0d]: got %h required %h", i, len_obs_q[i], len_exp_q[i]); end
    end
    checks++; if (msg_len !== 8'd255) begin errors++; $display("FAIL long_len_hold: got %0d required 255", msg_len); end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    h_ready = 1'b1;
    push_byte(8'h20, 1'b0);
    @(posedge clk);
    #1;
    h_ready = 1'b0;
    push_byte(8'h21, 1'b0);
    @(negedge clk);
    #1;
    checks++; if (h_valid !== 1'b1 || h_first !== 1'b0) begin
      errors++; $display("FAIL mid_body: valid %b first %b required 1 0", h_valid, h_first);
    end
    @(negedge clk);
    reset_ni = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (h_valid !== 1'b0 || h_byte !== 8'h00) begin errors++; $display("FAIL mid_reset_flush: valid %b byte %h required 0 00", h_valid, h_byte); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_s_ready: got %b required 0", s_ready); end
    checks++; if (msg_len !== 8'd0) begin errors++; $display("FAIL mid_reset_msg_len: got %0d required 0", msg_len); end
    @(negedge clk);
    reset_ni = 1'b1;
    clear_sb();
    @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1 || h_valid !== 1'b0) begin errors++; $display("FAIL mid_after_reset: ready %b valid %b required 1 0", s_ready, h_valid); end
    h_ready = 1'b1;
    push_byte(8'h10, 1'b1);
    idle(4);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL mid_pop_count: got %0d required 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== 10'h310) begin errors++; $display("FAIL mid_pop: got %h required 310", obs_q[0]); end
    end
    checks++; if (len_obs_q.size() != 1) begin errors++; $display("FAIL mid_len_pulses: got %0d required 1", len_obs_q.size()); end
    else begin
      checks++; if (len_obs_q[0] !== 9'd1) begin errors++; $display("FAIL mid_len: got %h required 001", len_obs_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full_then_back_to_back();
    test_long();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pearson_byte_feeder.md
PEARSON_BYTE_FEEDER -- requirements
Module: pearson_byte_feeder

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO depth in bytes (power of two, 2..64).
REQ-002 Parameter LEN_W, default 8, SHALL set the message-length counter width.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_ni  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 s_byte_i  input  8  SHALL carry the upstream message byte.
REQ-006 s_valid_i  input  1  SHALL indicate s_byte_i/s_last_i are valid.
REQ-007 s_last_i  input  1  SHALL mark the final byte of a message.
REQ-008 s_ready_o  output  1  SHALL indicate the feeder accepts a byte this cycle.
REQ-009 h_byte_o  output  8  SHALL carry the byte presented to the downstream Pearson hash stage.
REQ-010 h_valid_o  output  1  SHALL indicate h_byte_o and its flags are valid.
REQ-011 h_first_o  output  1  SHALL mark the first byte of a message; the hash stage clears h to 0 on it.
REQ-012 h_last_o  output  1  SHALL mark the last byte; the hash stage samples its digest after it.
REQ-013 h_ready_i  input  1  SHALL indicate the hash stage consumes the byte this cycle.
REQ-014 msg_len_o  output  LEN_W  SHALL give the byte count of the message just completed.
REQ-015 len_valid_o  output  1  SHALL pulse one cycle when msg_len_o is updated.
REQ-016 len_ovf_o  output  1  SHALL flag, with len_valid_o, that the message exceeded 2^LEN_W-1 bytes.

Function
REQ-017 Upstream push SHALL occur when s_valid_i && s_ready_o; downstream pop when h_valid_o && h_ready_i.
REQ-018 s_ready_o SHALL equal !full, registered-state-derived, no combinational path from h_ready_i.
REQ-019 Storage SHALL be a FIFO of {last, byte} entries, DEPTH deep, in-order.
REQ-020 A byte pushed in cycle N SHALL be visible on h_byte_o no earlier than N+1 (no bypass).
REQ-021 h_valid_o SHALL equal !empty; outputs SHALL hold stable while h_valid_o && !h_ready_i.
REQ-022 Simultaneous push and pop when not full SHALL leave occupancy unchanged; when full, push is blocked (s_ready_o=0) and pop proceeds.
REQ-023 Pointers SHALL wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.
REQ-024 Framing FSM, states START and BODY: h_first_o = (state==START) && h_valid_o.
REQ-025 START -> BODY on pop with last=0; BODY -> START on pop with last=1; START -> START on pop with last=1 (1-byte message gets first and last together).
REQ-026 Length counter SHALL clear on entry to START, increment per pop, saturate at 2^LEN_W-1.
REQ-027 On pop with last=1: msg_len_o <= saturated count including that byte, len_valid_o=1 next cycle, len_ovf_o=1 if the true count exceeded 2^LEN_W-1.
REQ-028 msg_len_o SHALL hold its value until the next completed message.
REQ-029 Push of s_byte_i while s_valid_i=0 SHALL be ignored; s_last_i is don't-care when s_valid_i=0.

Reset
REQ-030 While reset_ni=0 at a clock edge: FIFO empty, FSM=START, counter=0, msg_len_o=0, len_valid_o=0, len_ovf_o=0.
REQ-031 During and after reset, h_valid_o=0, h_first_o=0, h_last_o=0, h_byte_o=0, s_ready_o=0 in reset cycle then 1.
REQ-032 Reset mid-message SHALL discard buffered bytes; the next popped byte carries h_first_o=1.

Structure
REQ-033 Package pearson_pkg SHALL hold byte_t (8-bit), DEPTH and LEN_W defaults, and the FSM state enum.
REQ-034 FIFO SHALL be sub-module pearson_byte_fifo ({last,byte} width 9, DEPTH param); FSM and length logic stay in the top.

Verification
REQ-035 Push 0x41,0x42,0x43(last) with h_ready_i=1 -> pops 0x41(first),0x42,0x43(last); msg_len_o=3, len_valid_o one pulse.
REQ-036 Single byte 0x7E with last -> one pop with h_first_o=h_last_o=1; msg_len_o=1.
REQ-037 h_ready_i=0, push DEPTH=8 bytes -> s_ready_o=0 after 8th; hold stable; release -> 8 pops in order, s_ready_o=1 after first pop.
REQ-038 Full FIFO, s_valid_i=1, h_ready_i=1 same cycle -> pop occurs, push blocked, no byte lost or duplicated.
REQ-039 Message of 300 bytes -> msg_len_o=255, len_ovf_o=1 with len_valid_o.
REQ-040 reset_ni=0 after 2 of 4 bytes -> FIFO empty; next message 0x10(last) pops with h_first_o=1, msg_len_o=1.
